// File: rtl/mem_stage.sv
// MEM pipeline stage: runs the data-memory access for one EX/MEM op, formats
// store data and byte lanes, and loads the MEM/WB register for WB_stage.
//
// state | meaning
// IDLE  | ready for a new op; non-mem and misaligned ops retire from here
// BUSY  | bus strobe held, waiting for dmem_resp or timeout

package rv32i_types;
  typedef struct packed {
    logic       load_regfile;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] store_op;   // funct3: [1:0] is access size for loads and stores
  } rv32i_control_word;
endpackage

module mem_stage
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [31:0]       pc_plus4_in,
  input  logic [31:0]       logic_out_in,
  input  logic [31:0]       rs2_in,
  input  rv32i_control_word control_word_in,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [31:0]       dmem_address,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_byte_enable,
  input  logic              dmem_resp,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       logic_out,
  output logic [31:0]       MDR,
  output rv32i_control_word control_word,
  output logic              err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = 16;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          killed;
  logic          accept, is_mem, is_wr, misaligned, timeout_hit, done;
  logic [1:0]    off;
  logic [3:0]    be_fmt;
  logic [31:0]   wdata_fmt;

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid & in_ready & ~flush;
  assign is_mem      = control_word_in.mem_read | control_word_in.mem_write;
  assign is_wr       = control_word_in.mem_write;   // read+write resolves to write
  assign off         = logic_out_in[1:0];
  // cnt counts completed BUSY cycles, so the last allowed cycle sees TIMEOUT-1
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign done        = (state == BUSY) && (dmem_resp || timeout_hit);

  // Byte-lane / store-data formatting and alignment check from the access size
  always_comb begin
    be_fmt     = 4'b1111;
    wdata_fmt  = rs2_in;
    misaligned = 1'b0;
    case (control_word_in.store_op[1:0])
      2'b00: begin
        if (is_wr) begin
          be_fmt    = 4'b0001 << off;
          wdata_fmt = {4{rs2_in[7:0]}};
        end
      end
      2'b01: begin
        if (is_wr) begin
          be_fmt    = 4'b0011 << off;
          wdata_fmt = {2{rs2_in[15:0]}};
        end
        // a half at offset 1 still fits in the word; only offset 3 straddles
        misaligned = (off == 2'd3);
      end
      default: misaligned = (off != 2'd0);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: only aligned memory ops enter BUSY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && !misaligned) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes, wait counter and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      killed           <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      wb_valid         <= 1'b0;
      err              <= 1'b0;
      pc_plus4         <= '0;
      logic_out        <= '0;
      MDR              <= '0;
      control_word     <= '0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (accept) begin
          pc_plus4     <= pc_plus4_in;
          logic_out    <= logic_out_in;
          control_word <= control_word_in;
          killed       <= 1'b0;
          if (is_mem) begin
            dmem_address     <= {logic_out_in[31:2], 2'b00};
            dmem_wdata       <= wdata_fmt;
            dmem_byte_enable <= be_fmt;
            if (misaligned) begin
              wb_valid <= 1'b1;
              err      <= 1'b1;
            end else begin
              dmem_write <= is_wr;
              dmem_read  <= ~is_wr;
            end
          end else begin
            wb_valid <= 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (flush) killed <= 1'b1;
        if (done) begin
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          // a flush arriving on the completing cycle still kills the writeback
          wb_valid   <= ~(killed | flush);
          err        <= ~dmem_resp & ~(killed | flush);
          if (dmem_resp && dmem_read) MDR <= dmem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for reset/flush/idle-resp.
module tb_mem_stage;
  import rv32i_types::*;

  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, flush, dmem_resp;
  logic              in_ready, dmem_read, dmem_write, wb_valid, err;
  logic [31:0]       pc_plus4_in, logic_out_in, rs2_in, dmem_rdata;
  logic [31:0]       dmem_address, dmem_wdata, pc_plus4, logic_out, MDR;
  logic [3:0]        dmem_byte_enable;
  rv32i_control_word control_word_in, control_word;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .pc_plus4_in(pc_plus4_in), .logic_out_in(logic_out_in),
    .rs2_in(rs2_in), .control_word_in(control_word_in),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .pc_plus4(pc_plus4), .logic_out(logic_out), .MDR(MDR),
    .control_word(control_word), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        mr, mw;
    bit [2:0]  f3;
    bit [31:0] pc, lo, rs2, rdata;
    int        delay;      // resp in BUSY cycle 'delay'; 0 or >TO means never
    bit        fl;         // flush during first BUSY cycle
    bit [3:0]  e_be;
    bit [31:0] e_wd;
    bit        e_mis;
  } vec_t;

  int        n_cmp = 0;
  int        n_bad = 0;
  bit [31:0] exp_mdr = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit mr, input bit mw, input bit [2:0] f3,
                              input bit [31:0] pc, input bit [31:0] lo,
                              input bit [31:0] rs2, input bit [31:0] rdata,
                              input int delay, input bit fl, input bit [3:0] e_be,
                              input bit [31:0] e_wd, input bit e_mis);
    vec_t v;
    v.mr = mr; v.mw = mw; v.f3 = f3; v.pc = pc; v.lo = lo; v.rs2 = rs2;
    v.rdata = rdata; v.delay = delay; v.fl = fl;
    v.e_be = e_be; v.e_wd = e_wd; v.e_mis = e_mis;
    return v;
  endfunction

  // Reference: an access of nb bytes at offset off is legal iff it fits in the word
  function automatic vec_t model(input vec_t v);
    int nb, off;
    nb  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(v.lo[1:0]);
    v.e_mis = (v.mr || v.mw) && (off + nb > 4);
    if (v.mw) begin
      v.e_be = 4'(((1 << nb) - 1) << off);
      if (nb == 1)      v.e_wd = (v.rs2 & 32'hFF) * 32'h01010101;
      else if (nb == 2) v.e_wd = (v.rs2 & 32'hFFFF) * 32'h00010001;
      else              v.e_wd = v.rs2;
    end else begin
      v.e_be = 4'hF;
      v.e_wd = 32'h0;
    end
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    rv32i_control_word cw;
    bit mem, timed_out;
    int n_busy;
    cw = '0;
    cw.mem_read = v.mr; cw.mem_write = v.mw; cw.store_op = v.f3;
    cw.rd = v.pc[6:2]; cw.load_regfile = v.mr;
    mem = v.mr | v.mw;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; pc_plus4_in = v.pc; logic_out_in = v.lo;
    rs2_in = v.rs2; control_word_in = cw;
    @(negedge clk);
    in_valid = 1'b0;
    if (!mem || v.e_mis) begin
      chk("wb_valid_direct", 32'(wb_valid), 1);
      chk("err_direct", 32'(err), 32'(v.e_mis));
      chk("no_strobe", 32'(dmem_read | dmem_write), 0);
      chk("in_ready_direct", 32'(in_ready), 1);
      chk("logic_out", logic_out, v.lo);
      chk("pc_plus4", pc_plus4, v.pc);
      chk("control_word", 32'(control_word), 32'(cw));
      chk("mdr_kept", MDR, exp_mdr);
    end else begin
      timed_out = (v.delay == 0) || (v.delay > TO);
      n_busy = timed_out ? TO : v.delay;
      for (int i = 0; i < n_busy; i++) begin
        chk("rd_strobe", 32'(dmem_read), 32'(v.mr & ~v.mw));
        chk("wr_strobe", 32'(dmem_write), 32'(v.mw));
        chk("in_ready_busy", 32'(in_ready), 0);
        chk("wb_valid_busy", 32'(wb_valid), 0);
        chk("address", dmem_address, {v.lo[31:2], 2'b00});
        chk("byte_enable", 32'(dmem_byte_enable), 32'(v.e_be));
        if (v.mw) chk("wdata", dmem_wdata, v.e_wd);
        dmem_resp  = (i == v.delay - 1);
        dmem_rdata = v.rdata;
        flush      = v.fl && (i == 0);
        @(negedge clk);
        dmem_resp = 1'b0;
        flush     = 1'b0;
      end
      if (v.mr && !v.mw && !timed_out) exp_mdr = v.rdata;
      chk("strobe_dropped", 32'(dmem_read | dmem_write), 0);
      chk("in_ready_done", 32'(in_ready), 1);
      chk("wb_valid_done", 32'(wb_valid), 32'(!v.fl));
      chk("err_done", 32'(err), 32'(timed_out && !v.fl));
      chk("mdr", MDR, exp_mdr);
      if (!v.fl) chk("logic_out_mem", logic_out, v.lo);
    end
    @(negedge clk);
    chk("wb_valid_pulse_end", 32'(wb_valid), 0);
    chk("err_pulse_end", 32'(err), 0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; dmem_resp = 1'b0;
    pc_plus4_in = '0; logic_out_in = '0; rs2_in = '0; dmem_rdata = '0;
    control_word_in = '0;

    tbl[0]  = mk(0,0,3'd0, 32'h4,   32'h10,  32'h0,        32'h0,        0,0, 4'hF, 32'h0,        0);
    tbl[1]  = mk(1,0,3'd2, 32'h8,   32'h100, 32'h0,        32'hDEADBEEF, 3,0, 4'hF, 32'h0,        0);
    tbl[2]  = mk(0,1,3'd0, 32'hC,   32'h103, 32'hAB,       32'h0,        1,0, 4'h8, 32'hABABABAB, 0);
    tbl[3]  = mk(0,1,3'd1, 32'h10,  32'h102, 32'h1234,     32'h0,        2,0, 4'hC, 32'h12341234, 0);
    tbl[4]  = mk(1,0,3'd2, 32'h14,  32'h102, 32'h0,        32'h0,        1,0, 4'hF, 32'h0,        1);
    tbl[5]  = mk(0,1,3'd1, 32'h18,  32'h103, 32'h55,       32'h0,        1,0, 4'h0, 32'h0,        1);
    tbl[6]  = mk(1,0,3'd2, 32'h1C,  32'h200, 32'h0,        32'h12345678, 0,0, 4'hF, 32'h0,        0);
    tbl[7]  = mk(0,1,3'd2, 32'h20,  32'h300, 32'hCAFEF00D, 32'h0,        2,1, 4'hF, 32'hCAFEF00D, 0);
    tbl[8]  = mk(1,1,3'd2, 32'h24,  32'h40,  32'h11223344, 32'h99999999, 1,0, 4'hF, 32'h11223344, 0);
    tbl[9]  = mk(0,1,3'd1, 32'h28,  32'h101, 32'hBEEF,     32'h0,        4,0, 4'h6, 32'hBEEFBEEF, 0);
    tbl[10] = mk(1,0,3'd4, 32'h2C,  32'h107, 32'h0,        32'h00000055, 1,0, 4'hF, 32'h0,        0);

    #1;
    chk("rst_strobe", 32'(dmem_read | dmem_write), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_address", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", 32'(dmem_byte_enable), 0);
    chk("rst_mdr", MDR, 0);
    chk("rst_logic_out", logic_out, 0);
    chk("rst_pc_plus4", pc_plus4, 0);

    for (int i = 0; i < 11; i++) apply_vec(tbl[i]);

    // dmem_resp while idle must do nothing
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF0000;
    repeat (2) @(negedge clk);
    dmem_resp = 1'b0;
    chk("idle_resp_wb", 32'(wb_valid), 0);
    chk("idle_resp_mdr", MDR, exp_mdr);
    chk("idle_resp_ready", 32'(in_ready), 1);

    // flush in IDLE suppresses acceptance
    in_valid = 1'b1; flush = 1'b1;
    control_word_in = '0; control_word_in.mem_read = 1'b1; control_word_in.store_op = 3'd2;
    logic_out_in = 32'h500;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_strobe", 32'(dmem_read), 0);
    chk("idle_flush_ready", 32'(in_ready), 1);
    chk("idle_flush_wb", 32'(wb_valid), 0);

    // reset in the middle of BUSY
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_read", 32'(dmem_read), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 32'(dmem_read), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_wb", 32'(wb_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_mdr = 32'h0;
    @(negedge clk);
    chk("post_rst_read", 32'(dmem_read), 0);
    chk("post_rst_mdr", MDR, 0);
    apply_vec(tbl[1]);

    // randomized ops against the model
    for (int n = 0; n < 150; n++) begin
      int k;
      k = int'($urandom_range(0, 3));
      rv.mr = (k == 1) || (k == 3);
      rv.mw = (k == 2) || (k == 3);
      case ($urandom_range(0, 4))
        0: rv.f3 = 3'd0;
        1: rv.f3 = 3'd1;
        2: rv.f3 = 3'd2;
        3: rv.f3 = 3'd4;
        default: rv.f3 = 3'd5;
      endcase
      rv.pc    = $urandom;
      rv.lo    = $urandom;
      rv.rs2   = $urandom;
      rv.rdata = $urandom;
      rv.delay = int'($urandom_range(0, TO + 2));
      rv.fl    = ($urandom_range(0, 5) == 0);
      rv = model(rv);
      apply_vec(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
